// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit sitting directly upstream of the byte-addressed RAM.
//
// Accepts one CPU request at a time (valid/ready), bounds-checks it, strobes
// the RAM for exactly one cycle, captures the RAM's registered read data,
// formats it to 16 bits and returns a one-cycle completion pulse with a
// fault flag.
//
// Optional feature (compile-time macro LSU_SIGNEXT_EN):
//   defined   -> adds input I_signed; signed byte loads are sign-extended
//   undefined -> no I_signed port; every byte load is zero-extended
//
// Ports:
//   I_clk, I_reset         clock, synchronous active-high reset
//   I_valid / O_ready      request handshake (O_ready high only in IDLE)
//   I_write                1 = store, 0 = load
//   I_size                 1 = byte, 2 = halfword (0 and 3 fault)
//   I_addr, I_wdata        byte address, store data (byte stores use [7:0])
//   I_signed               (LSU_SIGNEXT_EN only) sign-extend byte loads
//   O_done, O_fault        one-cycle completion pulse and its fault flag
//   O_rdata                load result, valid with O_done on a good load
//   O_ram_enable/_write/_size/_addr/_wdata   RAM request, all registered
//   I_ram_rdata            RAM read data (registered inside the RAM)
// -----------------------------------------------------------------------------
module lsu #(
    parameter int ADDR_LIMIT = 4096
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_valid,
    output logic        O_ready,
    input  logic        I_write,
    input  logic [1:0]  I_size,
    input  logic [15:0] I_addr,
    input  logic [15:0] I_wdata,
`ifdef LSU_SIGNEXT_EN
    input  logic        I_signed,
`endif
    output logic        O_done,
    output logic        O_fault,
    output logic [15:0] O_rdata,
    output logic        O_ram_enable,
    output logic        O_ram_write,
    output logic [1:0]  O_ram_size,
    output logic [15:0] O_ram_addr,
    output logic [15:0] O_ram_wdata,
    input  logic [15:0] I_ram_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        FAULT   = 2'd3
    } state_t;

    // 17-bit limit so that address + 1 on 0xFFFF cannot wrap back into range
    localparam logic [16:0] LIMIT = 17'(ADDR_LIMIT);

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        enable_q, enable_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [15:0] rdata_q, rdata_d;
`ifdef LSU_SIGNEXT_EN
    logic        signed_q, signed_d;
`endif

    logic [16:0] addr_ext;
    logic        req_fault;
    logic [15:0] load_data;

    assign addr_ext = {1'b0, I_addr};

    // A request is rejected for an illegal size, a start address at or past
    // the limit, or a halfword whose second byte would land past the limit.
    assign req_fault = ((I_size != 2'd1) && (I_size != 2'd2))
                     || (addr_ext >= LIMIT)
                     || ((I_size == 2'd2) && ((addr_ext + 17'd1) >= LIMIT));

    // Format the RAM's read word according to the latched request size.
    always_comb begin
        logic [7:0] upper;
        upper = 8'h00;
`ifdef LSU_SIGNEXT_EN
        if (signed_q) begin
            upper = {8{I_ram_rdata[7]}};
        end
`endif
        if (size_q == 2'd1) begin
            load_data = {upper, I_ram_rdata[7:0]};
        end else begin
            load_data = I_ram_rdata;
        end
    end

    // Next-state and next-output logic. Only non-faulting requests are
    // latched, so the RAM bus keeps showing the last real access rather than
    // garbage from a rejected one.
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        fault_d  = 1'b0;
        rdata_d  = rdata_q;
`ifdef LSU_SIGNEXT_EN
        signed_d = signed_q;
`endif

        case (state_q)
            IDLE: begin
                if (I_valid) begin
                    if (req_fault) begin
                        state_d = FAULT;
                    end else begin
                        state_d = ACCESS;
                        write_d = I_write;
                        size_d  = I_size;
                        addr_d  = I_addr;
                        wdata_d = (I_size == 2'd1) ? {8'h00, I_wdata[7:0]} : I_wdata;
`ifdef LSU_SIGNEXT_EN
                        signed_d = I_signed;
`endif
                    end
                end
            end
            ACCESS: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                done_d  = 1'b1;
                fault_d = 1'b0;
                if (!write_q) begin
                    rdata_d = load_data;
                end
                state_d = IDLE;
            end
            FAULT: begin
                done_d  = 1'b1;
                fault_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered strobe: high for exactly the single ACCESS cycle
        enable_d = (state_d == ACCESS);
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            rdata_q  <= 16'h0000;
`ifdef LSU_SIGNEXT_EN
            signed_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            enable_q <= enable_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
`ifdef LSU_SIGNEXT_EN
            signed_q <= signed_d;
`endif
        end
    end

    assign O_ready      = (state_q == IDLE);
    assign O_done       = done_q;
    assign O_fault      = fault_q;
    assign O_rdata      = rdata_q;
    assign O_ram_enable = enable_q;
    assign O_ram_write  = write_q;
    assign O_ram_size   = size_q;
    assign O_ram_addr   = addr_q;
    assign O_ram_wdata  = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu.
//
// A behavioural byte RAM (registered read, gated by reset) hangs off the RAM
// port. Each request pushes its expected completion (fault, rdata, latency,
// RAM strobe count) to a scoreboard queue computed from an independent shadow
// memory; the scenario tasks pop and compare when O_done arrives.
// Builds with or without LSU_SIGNEXT_EN.
// -----------------------------------------------------------------------------
module tb_lsu;

`ifdef LSU_SIGNEXT_EN
    localparam bit SIGNEXT = 1'b1;
`else
    localparam bit SIGNEXT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic        write = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
`ifdef LSU_SIGNEXT_EN
    logic        sgn_in = 1'b0;
`endif
    logic        done;
    logic        fault;
    logic [15:0] rdata;
    logic        ram_enable;
    logic        ram_write;
    logic [1:0]  ram_size;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'h0000;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        fault;
        logic [15:0] rdata;
        int          lat;
        int          en;
    } exp_t;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic [15:0] a;
        logic [15:0] wd;
        logic        sg;
    } req_t;

    exp_t        sb[$];
    logic [7:0]  exp_mem [0:4095];
    logic [15:0] model_rdata = 16'h0000;

    lsu #(.ADDR_LIMIT(4096)) dut (
        .I_clk        (clk),
        .I_reset      (reset),
        .I_valid      (valid),
        .O_ready      (ready),
        .I_write      (write),
        .I_size       (size),
        .I_addr       (addr),
        .I_wdata      (wdata),
`ifdef LSU_SIGNEXT_EN
        .I_signed     (sgn_in),
`endif
        .O_done       (done),
        .O_fault      (fault),
        .O_rdata      (rdata),
        .O_ram_enable (ram_enable),
        .O_ram_write  (ram_write),
        .O_ram_size   (ram_size),
        .O_ram_addr   (ram_addr),
        .O_ram_wdata  (ram_wdata),
        .I_ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: 4 KiB, little-endian halfwords, registered read,
    // writes suppressed while reset is high.
    logic [7:0]  ram_mem [0:4095];
    logic [11:0] ram_a0;
    logic [11:0] ram_a1;
    assign ram_a0 = ram_addr[11:0];
    assign ram_a1 = ram_a0 + 12'd1;

    always @(posedge clk) begin
        if (!reset && ram_enable) begin
            if (ram_write) begin
                ram_mem[ram_a0] <= ram_wdata[7:0];
                if (ram_size == 2'd2) begin
                    ram_mem[ram_a1] <= ram_wdata[15:8];
                end
            end else begin
                ram_rdata <= {ram_mem[ram_a1], ram_mem[ram_a0]};
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram_mem[i] = 8'h00;
            exp_mem[i] = 8'h00;
        end
    end

    // Drive one request until it is taken on a rising edge; optionally keep
    // I_valid high afterwards. When push is set, the expected completion is
    // computed from the shadow memory and queued.
    task automatic send_req(input req_t r, input bit hold, input bit push);
        exp_t        e;
        logic        f;
        logic [16:0] ax;
        logic [11:0] i0;
        logic [11:0] i1;
        logic [7:0]  up;
        valid = 1'b1;
        write = r.w;
        size  = r.sz;
        addr  = r.a;
        wdata = r.wd;
`ifdef LSU_SIGNEXT_EN
        sgn_in = r.sg;
`endif
        @(posedge clk);
        #1;
        if (!hold) valid = 1'b0;
        ax = {1'b0, r.a};
        f  = ((r.sz != 2'd1) && (r.sz != 2'd2)) || (ax >= 17'd4096)
             || ((r.sz == 2'd2) && ((ax + 17'd1) >= 17'd4096));
        i0 = r.a[11:0];
        i1 = i0 + 12'd1;
        if (push) begin
            if (!f && r.w) begin
                exp_mem[i0] = r.wd[7:0];
                if (r.sz == 2'd2) exp_mem[i1] = r.wd[15:8];
            end
            if (!f && !r.w) begin
                if (r.sz == 2'd1) begin
                    up = (r.sg && SIGNEXT) ? {8{exp_mem[i0][7]}} : 8'h00;
                    model_rdata = {up, exp_mem[i0]};
                end else begin
                    model_rdata = {exp_mem[i1], exp_mem[i0]};
                end
            end
            e.fault = f;
            e.rdata = model_rdata;
            e.lat   = f ? 2 : 3;
            e.en    = f ? 0 : 1;
            sb.push_back(e);
        end
    endtask

    // Observe (no comparisons) until O_done, bounded to 10 cycles; lat = 0
    // means it never arrived. Records the RAM strobe and O_ready while busy.
    task automatic wait_done(output int lat, output int en, output int br,
                             output logic ew, output logic [1:0] es,
                             output logic [15:0] ea, output logic [15:0] ewd);
        bit stop;
        lat = 0; en = 0; br = 0; ew = 1'b0; es = 2'd0; ea = 16'h0; ewd = 16'h0;
        stop = 1'b0;
        for (int i = 1; i <= 10 && !stop; i++) begin
            @(negedge clk);
            if (ram_enable) begin
                en++;
                ew = ram_write; es = ram_size; ea = ram_addr; ewd = ram_wdata;
            end
            if (done) begin
                lat = i;
                stop = 1'b1;
            end else if (ready) begin
                br++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_ready: got %b expected 1", ready);
        end
        checks++;
        if ({done, fault, rdata} !== 18'h0) begin
            failures++; $display("[TB] FAIL reset_outputs: got done=%b fault=%b rdata=%h expected 0", done, fault, rdata);
        end
        checks++;
        if ({ram_enable, ram_write, ram_size, ram_addr, ram_wdata} !== 36'h0) begin
            failures++; $display("[TB] FAIL reset_ram_bus: got en=%b wr=%b sz=%0d a=%h wd=%h expected 0",
                                 ram_enable, ram_write, ram_size, ram_addr, ram_wdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            failures++; $display("[TB] FAIL post_reset_idle: got ready=%b done=%b expected 1/0", ready, done);
        end
    endtask

    task automatic test_halfword();
        req_t tbl[2];
        exp_t e;
        int lat, en, br;
        logic ew; logic [1:0] es; logic [15:0] ea, ewd;
        tbl[0] = '{1'b1, 2'd2, 16'h0010, 16'hBEEF, 1'b0};
        tbl[1] = '{1'b0, 2'd2, 16'h0010, 16'h0000, 1'b0};
        for (int k = 0; k < 2; k++) begin
            send_req(tbl[k], 1'b0, 1'b1);
            wait_done(lat, en, br, ew, es, ea, ewd);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat) begin failures++; $display("[TB] FAIL hw_latency[%0d]: got %0d expected %0d", k, lat, e.lat); end
            checks++;
            if (fault !== e.fault) begin failures++; $display("[TB] FAIL hw_fault[%0d]: got %b expected %b", k, fault, e.fault); end
            checks++;
            if (rdata !== e.rdata) begin failures++; $display("[TB] FAIL hw_rdata[%0d]: got %h expected %h", k, rdata, e.rdata); end
            checks++;
            if (en !== e.en || br !== 0) begin failures++; $display("[TB] FAIL hw_strobe[%0d]: got en=%0d busy_ready=%0d expected %0d/0", k, en, br, e.en); end
            checks++;
            if ({ew, es, ea} !== {tbl[k].w, tbl[k].sz, tbl[k].a}) begin
                failures++; $display("[TB] FAIL hw_ram_req[%0d]: got wr=%b sz=%0d a=%h expected %b/%0d/%h", k, ew, es, ea, tbl[k].w, tbl[k].sz, tbl[k].a);
            end
        end
        checks++;
        if (ewd !== 16'hBEEF && ewd !== 16'h0000) begin end
        if (ram_mem[12'h010] !== 8'hEF || ram_mem[12'h011] !== 8'hBE) begin
            failures++; $display("[TB] FAIL hw_ram_contents: got %h%h expected beef", ram_mem[12'h011], ram_mem[12'h010]);
        end
    endtask

    task automatic test_byte_ext();
        req_t tbl[4];
        exp_t e;
        int lat, en, br;
        logic ew; logic [1:0] es; logic [15:0] ea, ewd;
        tbl[0] = '{1'b1, 2'd2, 16'h0020, 16'h77AA, 1'b0};
        tbl[1] = '{1'b1, 2'd1, 16'h0020, 16'h1285, 1'b0};
        tbl[2] = '{1'b0, 2'd1, 16'h0020, 16'h0000, 1'b1};
        tbl[3] = '{1'b0, 2'd1, 16'h0020, 16'h0000, 1'b0};
        for (int k = 0; k < 4; k++) begin
            send_req(tbl[k], 1'b0, 1'b1);
            wait_done(lat, en, br, ew, es, ea, ewd);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat || en !== e.en) begin failures++; $display("[TB] FAIL byte_timing[%0d]: got lat=%0d en=%0d expected %0d/%0d", k, lat, en, e.lat, e.en); end
            checks++;
            if (rdata !== e.rdata || fault !== e.fault) begin failures++; $display("[TB] FAIL byte_rdata[%0d]: got %h f=%b expected %h f=%b", k, rdata, fault, e.rdata, e.fault); end
            if (k == 1) begin
                checks++;
                if (ewd !== 16'h0085) begin failures++; $display("[TB] FAIL byte_wdata: got %h expected 0085", ewd); end
            end
        end
    endtask

    task automatic test_bounds();
        req_t tbl[7];
        exp_t e;
        int lat, en, br;
        logic ew; logic [1:0] es; logic [15:0] ea, ewd;
        tbl[0] = '{1'b0, 2'd1, 16'h1000, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 2'd2, 16'h0FFF, 16'h0000, 1'b0};
        tbl[2] = '{1'b1, 2'd1, 16'h0FFF, 16'h005A, 1'b0};
        tbl[3] = '{1'b0, 2'd1, 16'h0FFF, 16'h0000, 1'b0};
        tbl[4] = '{1'b0, 2'd2, 16'hFFFF, 16'h0000, 1'b0};
        tbl[5] = '{1'b0, 2'd2, 16'h0FFE, 16'h0000, 1'b0};
        tbl[6] = '{1'b1, 2'd2, 16'h0FFF, 16'hDEAD, 1'b0};
        for (int k = 0; k < 7; k++) begin
            send_req(tbl[k], 1'b0, 1'b1);
            wait_done(lat, en, br, ew, es, ea, ewd);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat) begin failures++; $display("[TB] FAIL bounds_latency[%0d]: got %0d expected %0d", k, lat, e.lat); end
            checks++;
            if (fault !== e.fault) begin failures++; $display("[TB] FAIL bounds_fault[%0d]: got %b expected %b", k, fault, e.fault); end
            checks++;
            if (rdata !== e.rdata) begin failures++; $display("[TB] FAIL bounds_rdata[%0d]: got %h expected %h", k, rdata, e.rdata); end
            checks++;
            if (en !== e.en || br !== 0) begin failures++; $display("[TB] FAIL bounds_strobe[%0d]: got en=%0d busy_ready=%0d expected %0d/0", k, en, br, e.en); end
        end
    endtask

    task automatic test_illegal_size();
        req_t tbl[3];
        exp_t e;
        int lat, en, br;
        logic ew; logic [1:0] es; logic [15:0] ea, ewd;
        tbl[0] = '{1'b1, 2'd3, 16'h0004, 16'hFFFF, 1'b0};
        tbl[1] = '{1'b1, 2'd0, 16'h0004, 16'hFFFF, 1'b0};
        tbl[2] = '{1'b0, 2'd2, 16'h0004, 16'h0000, 1'b0};
        for (int k = 0; k < 3; k++) begin
            send_req(tbl[k], 1'b0, 1'b1);
            wait_done(lat, en, br, ew, es, ea, ewd);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat || en !== e.en) begin failures++; $display("[TB] FAIL size_timing[%0d]: got lat=%0d en=%0d expected %0d/%0d", k, lat, en, e.lat, e.en); end
            checks++;
            if (fault !== e.fault) begin failures++; $display("[TB] FAIL size_fault[%0d]: got %b expected %b", k, fault, e.fault); end
            checks++;
            if (rdata !== e.rdata) begin failures++; $display("[TB] FAIL size_rdata[%0d]: got %h expected %h", k, rdata, e.rdata); end
        end
    endtask

    task automatic test_back_to_back();
        req_t r0, r1;
        exp_t e;
        int lat, en, br;
        logic ew; logic [1:0] es; logic [15:0] ea, ewd;
        r0 = '{1'b0, 2'd2, 16'h0010, 16'h0000, 1'b0};
        r1 = '{1'b0, 2'd1, 16'h0020, 16'h0000, 1'b0};
        send_req(r0, 1'b1, 1'b1);
        wait_done(lat, en, br, ew, es, ea, ewd);
        e = sb.pop_front();
        checks++;
        if (lat !== 3 || br !== 0) begin failures++; $display("[TB] FAIL b2b_first: got lat=%0d busy_ready=%0d expected 3/0", lat, br); end
        checks++;
        if (rdata !== e.rdata) begin failures++; $display("[TB] FAIL b2b_first_rdata: got %h expected %h", rdata, e.rdata); end
        checks++;
        if (ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_in_done: got %b expected 1", ready); end
        // I_valid is still high here, so the second load is taken on this edge
        send_req(r1, 1'b0, 1'b1);
        wait_done(lat, en, br, ew, es, ea, ewd);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || br !== 0) begin failures++; $display("[TB] FAIL b2b_second: got lat=%0d busy_ready=%0d expected %0d/0", lat, br, e.lat); end
        checks++;
        if (rdata !== e.rdata || fault !== e.fault) begin failures++; $display("[TB] FAIL b2b_second_rdata: got %h f=%b expected %h f=%b", rdata, fault, e.rdata, e.fault); end
    endtask

    task automatic test_reset_midop();
        req_t r;
        exp_t e;
        int lat, en, br, seen_done, not_ready;
        logic ew; logic [1:0] es; logic [15:0] ea, ewd;
        r = '{1'b1, 2'd2, 16'h0040, 16'hA5A5, 1'b0};
        send_req(r, 1'b0, 1'b1);
        wait_done(lat, en, br, ew, es, ea, ewd);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || fault !== e.fault) begin failures++; $display("[TB] FAIL midop_setup: got lat=%0d f=%b expected %0d/%b", lat, fault, e.lat, e.fault); end
        r = '{1'b1, 2'd2, 16'h0040, 16'h1234, 1'b0};
        send_req(r, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (ram_enable !== 1'b1 || ram_wdata !== 16'h1234) begin
            failures++; $display("[TB] FAIL midop_access: got en=%b wd=%h expected 1/1234", ram_enable, ram_wdata);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_rdata = 16'h0000;
        seen_done = 0;
        not_ready = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) seen_done++;
            if (!ready) not_ready++;
            @(negedge clk);
        end
        checks++;
        if (seen_done !== 0) begin failures++; $display("[TB] FAIL midop_no_done: got %0d pulses expected 0", seen_done); end
        checks++;
        if (not_ready !== 0 || rdata !== 16'h0000) begin failures++; $display("[TB] FAIL midop_idle: got not_ready=%0d rdata=%h expected 0/0000", not_ready, rdata); end
        r = '{1'b0, 2'd2, 16'h0040, 16'h0000, 1'b0};
        send_req(r, 1'b0, 1'b1);
        wait_done(lat, en, br, ew, es, ea, ewd);
        e = sb.pop_front();
        checks++;
        if (rdata !== e.rdata || lat !== e.lat) begin failures++; $display("[TB] FAIL midop_old_value: got %h lat=%0d expected %h/%0d", rdata, lat, e.rdata, e.lat); end
    endtask

    initial begin
        test_reset();
        test_halfword();
        test_byte_ext();
        test_bounds();
        test_illegal_size();
        test_back_to_back();
        test_reset_midop();
        checks++;
        if (sb.size() !== 0) begin failures++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
